// File: rtl/sent_tx_frame_scheduler.sv
// sent_tx_frame_scheduler
//   Sequences SENT transmit frames: SYNC, STATUS, data nibbles, CRC and an
//   optional PAUSE that pads every frame to FRAME_TICKS. Fast-channel words
//   are pulled from the TX FIFO and packed per frame_format. The CRC-4 is
//   computed over the data nibbles. Slow-channel serial bits are multiplexed
//   into the status nibble. One pulse request at a time goes to the pulse
//   generator.
// Ports
//   clk_tx, reset_tx        clock, synchronous active-high reset
//   enable, frame_format    run control and frame layout (0 = none)
//   status_in               status nibble bits [1:0]
//   fifo_empty, data_fifo_in, read_enable_fifo   TX FIFO pop interface
//   serial_valid, channel_format, serial_b2_in, serial_b3_in, serial_ack
//                           slow-channel message handshake
//   pulse_start, pulse_ticks, pulse_done         pulse generator handshake
//   busy                    high outside IDLE
//   overrun                 sticky: a frame left less than one nibble of pause
module sent_tx_frame_scheduler #(
  parameter int unsigned FRAME_TICKS = 282,
  parameter bit          PAUSE_EN    = 1'b1,
  parameter int unsigned SYNC_TICKS  = 56,
  parameter int unsigned TICK_W      = 9
) (
  input  logic              clk_tx,
  input  logic              reset_tx,
  input  logic              enable,
  input  logic [2:0]        frame_format,
  input  logic [1:0]        status_in,
  input  logic              fifo_empty,
  input  logic [15:0]       data_fifo_in,
  output logic              read_enable_fifo,
  input  logic              serial_valid,
  input  logic              channel_format,
  input  logic [17:0]       serial_b2_in,
  input  logic [17:0]       serial_b3_in,
  output logic              serial_ack,
  output logic              pulse_start,
  output logic [TICK_W-1:0] pulse_ticks,
  input  logic              pulse_done,
  output logic              busy,
  output logic              overrun
);

  localparam logic [TICK_W-1:0] MIN_T   = TICK_W'(12);
  localparam logic [TICK_W:0]   FRAME_W = (TICK_W+1)'(FRAME_TICKS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SYNC, S_STATUS, S_DATA, S_CRC, S_PAUSE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         fmt_q, fmt_d;
  logic [15:0]        w0_q, w0_d, w1_q, w1_d;
  logic [1:0]         pop_cnt_q, pop_cnt_d, lat_cnt_q, lat_cnt_d;
  logic               cap_q, cap_d;
  logic [2:0]         nib_idx_q, nib_idx_d;
  logic [TICK_W-1:0]  sum_q, sum_d;
  logic [4:0]         k_q, k_d;
  logic [17:0]        b2_q, b2_d, b3_q, b3_d;
  logic               cf_q, cf_d;
  logic [7:0]         sec_cnt_q, sec_cnt_d;
  logic               read_enable_fifo_q, read_enable_fifo_d;
  logic               serial_ack_q, serial_ack_d;
  logic               pulse_start_q, pulse_start_d;
  logic [TICK_W-1:0]  pulse_ticks_q, pulse_ticks_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  logic [1:0]         words_c;
  logic [2:0]         n_nib_c;
  logic [23:0]        data_vec_c, data_sh_c;
  logic [3:0]         nib_c, crc_c, status_nib_c;
  logic [4:0]         k_last_c, sidx_c;
  logic [17:0]        b2_sh_c, b3_sh_c;
  logic [TICK_W:0]    sum_ext_c;
  logic               late_c;
  logic [TICK_W-1:0]  pause_ticks_c;
  logic               advance_c;

  // Multiply by x^4 modulo x^4+x^3+x^2+1 (the CRC table entry for c).
  function automatic logic [3:0] crc_mul16(input logic [3:0] c);
    logic [7:0] r;
    r = {c, 4'b0000};
    for (int b = 7; b >= 4; b--) begin
      if (r[b]) r = r ^ (8'h1D << (b - 4));
    end
    return r[3:0];
  endfunction

  // Frame layout: words to pop, nibble count, and the packed data (MSN first).
  always_comb begin
    words_c = (fmt_q == 3'd1 || fmt_q == 3'd6 || fmt_q == 3'd7) ? 2'd2 : 2'd1;
    case (fmt_q)
      3'd2:    n_nib_c = 3'd3;
      3'd3:    n_nib_c = 3'd4;
      default: n_nib_c = 3'd6;
    endcase
    case (fmt_q)
      3'd1:    data_vec_c = {w0_q[11:0], w1_q[11:0]};
      3'd2:    data_vec_c = {w0_q[11:0], 12'h000};
      3'd3:    data_vec_c = {1'b0, w0_q[11:9], 1'b0, w0_q[8:6],
                             1'b0, w0_q[5:3], 1'b0, w0_q[2:0], 8'h00};
      3'd4:    data_vec_c = {w0_q[11:0], sec_cnt_q, ~w0_q[11:8]};
      3'd5:    data_vec_c = {w0_q[11:0], 12'h000};
      3'd6:    data_vec_c = {w0_q[13:0], w1_q[9:0]};
      3'd7:    data_vec_c = {w0_q, w1_q[7:0]};
      default: data_vec_c = 24'h000000;
    endcase
    data_sh_c = data_vec_c << {nib_idx_q, 2'b00};
    nib_c     = data_sh_c[23:20];
  end

  // CRC-4 over the valid data nibbles, seed 5, with the trailing zero-nibble step.
  always_comb begin
    crc_c = 4'h5;
    for (int i = 0; i < 6; i++) begin
      if (3'(i) < n_nib_c) crc_c = crc_mul16(crc_c) ^ data_vec_c[23 - 4*i -: 4];
    end
    crc_c = crc_mul16(crc_c);
  end

  // Slow-channel bit selection and pause length.
  always_comb begin
    k_last_c      = cf_q ? 5'd17 : 5'd15;
    sidx_c        = k_last_c - k_q;
    b2_sh_c       = b2_q >> sidx_c;
    b3_sh_c       = b3_q >> sidx_c;
    status_nib_c  = {b3_sh_c[0], b2_sh_c[0], status_in};
    sum_ext_c     = {1'b0, sum_q};
    late_c        = sum_ext_c > (FRAME_W - (TICK_W+1)'(12));
    pause_ticks_c = late_c ? MIN_T : TICK_W'(FRAME_W - sum_ext_c);
    advance_c     = !pulse_start_q && pulse_done;
  end

  // Next-state and output logic.
  always_comb begin
    logic              issue;
    logic              sum_clr;
    logic              frame_end;
    logic [TICK_W-1:0] issue_ticks;

    state_d            = state_q;
    fmt_d              = fmt_q;
    w0_d               = w0_q;
    w1_d               = w1_q;
    pop_cnt_d          = pop_cnt_q;
    lat_cnt_d          = lat_cnt_q;
    cap_d              = 1'b0;
    nib_idx_d          = nib_idx_q;
    sum_d              = sum_q;
    k_d                = k_q;
    b2_d               = b2_q;
    b3_d               = b3_q;
    cf_d               = cf_q;
    sec_cnt_d          = sec_cnt_q;
    overrun_d          = overrun_q;
    read_enable_fifo_d = 1'b0;
    serial_ack_d       = 1'b0;
    pulse_start_d      = 1'b0;
    pulse_ticks_d      = pulse_ticks_q;
    issue              = 1'b0;
    sum_clr            = 1'b0;
    frame_end          = 1'b0;
    issue_ticks        = '0;

    case (state_q)
      S_IDLE: begin
        if (enable && frame_format != 3'd0) begin
          state_d   = S_LOAD;
          fmt_d     = frame_format;
          pop_cnt_d = 2'd0;
          lat_cnt_d = 2'd0;
        end
      end
      S_LOAD: begin
        if (cap_q) begin
          // Word popped last cycle is on data_fifo_in now.
          if (lat_cnt_q == 2'd0) w0_d = data_fifo_in;
          else                   w1_d = data_fifo_in;
          lat_cnt_d = lat_cnt_q + 2'd1;
          if (lat_cnt_q + 2'd1 == words_c) begin
            state_d     = S_SYNC;
            issue       = 1'b1;
            issue_ticks = TICK_W'(SYNC_TICKS);
            sum_clr     = 1'b1;
            nib_idx_d   = 3'd0;
            // A new slow-channel message can only begin on frame 0.
            if (k_q == 5'd0) begin
              if (serial_valid) begin
                b2_d         = serial_b2_in;
                b3_d         = serial_b3_in;
                cf_d         = channel_format;
                serial_ack_d = 1'b1;
              end else begin
                b2_d = '0;
                b3_d = '0;
              end
            end
          end
        end else if (read_enable_fifo_q) begin
          cap_d = 1'b1;
        end else if (pop_cnt_q < words_c && !fifo_empty) begin
          read_enable_fifo_d = 1'b1;
          pop_cnt_d          = pop_cnt_q + 2'd1;
        end
      end
      S_SYNC: begin
        if (advance_c) begin
          state_d     = S_STATUS;
          issue       = 1'b1;
          issue_ticks = MIN_T + TICK_W'(status_nib_c);
        end
      end
      S_STATUS: begin
        if (advance_c) begin
          state_d     = S_DATA;
          issue       = 1'b1;
          issue_ticks = MIN_T + TICK_W'(nib_c);
          nib_idx_d   = nib_idx_q + 3'd1;
          k_d         = (k_q == k_last_c) ? 5'd0 : k_q + 5'd1;
        end
      end
      S_DATA: begin
        if (advance_c) begin
          issue = 1'b1;
          if (nib_idx_q == n_nib_c) begin
            state_d     = S_CRC;
            issue_ticks = MIN_T + TICK_W'(crc_c);
          end else begin
            issue_ticks = MIN_T + TICK_W'(nib_c);
            nib_idx_d   = nib_idx_q + 3'd1;
          end
        end
      end
      S_CRC: begin
        if (advance_c) begin
          if (fmt_q == 3'd4) sec_cnt_d = sec_cnt_q + 8'd1;
          if (PAUSE_EN) begin
            state_d     = S_PAUSE;
            issue       = 1'b1;
            issue_ticks = pause_ticks_c;
            if (late_c) overrun_d = 1'b1;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (advance_c) frame_end = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_end) begin
      if (enable && frame_format != 3'd0) begin
        state_d   = S_LOAD;
        fmt_d     = frame_format;
        pop_cnt_d = 2'd0;
        lat_cnt_d = 2'd0;
      end else begin
        state_d = S_IDLE;
      end
    end

    if (issue) begin
      pulse_start_d = 1'b1;
      pulse_ticks_d = issue_ticks;
      sum_d         = (sum_clr ? '0 : sum_q) + issue_ticks;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      state_q            <= S_IDLE;
      fmt_q              <= '0;
      w0_q               <= '0;
      w1_q               <= '0;
      pop_cnt_q          <= '0;
      lat_cnt_q          <= '0;
      cap_q              <= 1'b0;
      nib_idx_q          <= '0;
      sum_q              <= '0;
      k_q                <= '0;
      b2_q               <= '0;
      b3_q               <= '0;
      cf_q               <= 1'b0;
      sec_cnt_q          <= '0;
      read_enable_fifo_q <= 1'b0;
      serial_ack_q       <= 1'b0;
      pulse_start_q      <= 1'b0;
      pulse_ticks_q      <= '0;
      busy_q             <= 1'b0;
      overrun_q          <= 1'b0;
    end else begin
      state_q            <= state_d;
      fmt_q              <= fmt_d;
      w0_q               <= w0_d;
      w1_q               <= w1_d;
      pop_cnt_q          <= pop_cnt_d;
      lat_cnt_q          <= lat_cnt_d;
      cap_q              <= cap_d;
      nib_idx_q          <= nib_idx_d;
      sum_q              <= sum_d;
      k_q                <= k_d;
      b2_q               <= b2_d;
      b3_q               <= b3_d;
      cf_q               <= cf_d;
      sec_cnt_q          <= sec_cnt_d;
      read_enable_fifo_q <= read_enable_fifo_d;
      serial_ack_q       <= serial_ack_d;
      pulse_start_q      <= pulse_start_d;
      pulse_ticks_q      <= pulse_ticks_d;
      busy_q             <= busy_d;
      overrun_q          <= overrun_d;
    end
  end

  assign read_enable_fifo = read_enable_fifo_q;
  assign serial_ack       = serial_ack_q;
  assign pulse_start      = pulse_start_q;
  assign pulse_ticks      = pulse_ticks_q;
  assign busy             = busy_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_sent_tx_frame_scheduler.sv
// tb_sent_tx_frame_scheduler
//   Directed bench for sent_tx_frame_scheduler. A second instance with a
//   short frame length shadows the first to exercise the pause clamp.
`timescale 1ns/1ps
module tb_sent_tx_frame_scheduler;

  localparam int unsigned TICK_W = 9;

  logic              clk_tx = 1'b0;
  logic              reset_tx, enable, serial_valid, channel_format, pulse_done;
  logic [2:0]        frame_format;
  logic [1:0]        status_in;
  logic              fifo_empty;
  logic [15:0]       data_fifo_in;
  logic [17:0]       serial_b2_in, serial_b3_in;
  logic              read_enable_fifo, serial_ack, pulse_start, busy, overrun;
  logic [TICK_W-1:0] pulse_ticks;
  logic              b_hold, b_reset;
  logic              b_read_enable_fifo, b_serial_ack, b_pulse_start, b_busy, b_overrun;
  logic [TICK_W-1:0] b_pulse_ticks;

  always #5 clk_tx = ~clk_tx;

  sent_tx_frame_scheduler dut (
    .clk_tx(clk_tx), .reset_tx(reset_tx), .enable(enable),
    .frame_format(frame_format), .status_in(status_in),
    .fifo_empty(fifo_empty), .data_fifo_in(data_fifo_in),
    .read_enable_fifo(read_enable_fifo), .serial_valid(serial_valid),
    .channel_format(channel_format), .serial_b2_in(serial_b2_in),
    .serial_b3_in(serial_b3_in), .serial_ack(serial_ack),
    .pulse_start(pulse_start), .pulse_ticks(pulse_ticks),
    .pulse_done(pulse_done), .busy(busy), .overrun(overrun)
  );

  assign b_reset = reset_tx | b_hold;

  sent_tx_frame_scheduler #(.FRAME_TICKS(150)) dut_short (
    .clk_tx(clk_tx), .reset_tx(b_reset), .enable(enable),
    .frame_format(frame_format), .status_in(status_in),
    .fifo_empty(fifo_empty), .data_fifo_in(data_fifo_in),
    .read_enable_fifo(b_read_enable_fifo), .serial_valid(serial_valid),
    .channel_format(channel_format), .serial_b2_in(serial_b2_in),
    .serial_b3_in(serial_b3_in), .serial_ack(b_serial_ack),
    .pulse_start(b_pulse_start), .pulse_ticks(b_pulse_ticks),
    .pulse_done(pulse_done), .busy(b_busy), .overrun(b_overrun)
  );

  // FIFO model: initial side writes, model side pops.
  logic [15:0] mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  // Pulse generator model, pulse log and event counters.
  logic [TICK_W-1:0] seen[$];
  logic [TICK_W-1:0] seen_b[$];
  int dly   = 0;
  int n_ack = 0;
  int n_rd  = 0;

  always @(posedge clk_tx) begin
    if (reset_tx) begin
      pulse_done <= 1'b0;
      dly        <= 0;
    end else begin
      pulse_done <= 1'b0;
      if (pulse_start) begin
        seen.push_back(pulse_ticks);
        dly <= 3;
      end else if (dly == 1) begin
        pulse_done <= 1'b1;
        dly        <= 0;
      end else if (dly > 1) begin
        dly <= dly - 1;
      end
      if (b_pulse_start) seen_b.push_back(b_pulse_ticks);
      if (serial_ack) n_ack <= n_ack + 1;
      if (read_enable_fifo) begin
        n_rd <= n_rd + 1;
        if (rd_ptr != wr_ptr) begin
          data_fifo_in <= mem[rd_ptr[5:0]];
          rd_ptr       <= rd_ptr + 1;
        end
      end
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_pulses(input int target, input string tag);
    int n = 0;
    while (seen.size() < target && n < 3000) begin
      @(negedge clk_tx);
      n++;
    end
    check_eq(tag, 32'(seen.size() >= target), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk_tx);
    while (busy && n < 3000) begin
      @(negedge clk_tx);
      n++;
    end
    check_eq(tag, 32'(busy), 0);
  endtask

  task automatic check_frame(input string tag, input int base, input int e[$]);
    check_eq({tag, "_npulses"}, seen.size() - base, e.size());
    for (int i = 0; i < e.size(); i++)
      check_eq($sformatf("%s_p%0d", tag, i), 32'(seen[base + i]), e[i]);
  endtask

  // Run one frame: start, drop enable after `drop_at` pulses, wait for IDLE.
  task automatic run_one(input string tag, input logic [2:0] fmt, input int drop_at);
    int base;
    base = seen.size();
    frame_format = fmt;
    enable = 1'b1;
    wait_pulses(base + drop_at, {tag, "_start"});
    enable = 1'b0;
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    int base, bbase, rd0, s0, n;
    int e[$];
    reset_tx = 1'b1; enable = 1'b0; frame_format = 3'd0; status_in = 2'd0;
    serial_valid = 1'b0; channel_format = 1'b0; serial_b2_in = '0; serial_b3_in = '0;
    b_hold = 1'b1;
    repeat (3) @(posedge clk_tx);
    @(negedge clk_tx);
    check_eq("rst_pulse_start", 32'(pulse_start), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_read_en", 32'(read_enable_fifo), 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    reset_tx = 1'b0;

    // fmt1, all-zero words: CRC nibble 5, pause 125.
    push(16'h0000); push(16'h0000);
    base = seen.size();
    run_one("fmt1", 3'd1, 1);
    e = '{56, 12, 12, 12, 12, 12, 12, 12, 17, 125};
    check_frame("fmt1", base, e);

    // fmt2 with empty FIFO: nothing starts until the word arrives.
    base = seen.size(); rd0 = n_rd;
    frame_format = 3'd2; enable = 1'b1;
    repeat (20) @(negedge clk_tx);
    check_eq("fmt2_no_start", seen.size() - base, 0);
    check_eq("fmt2_no_pop", n_rd - rd0, 0);
    check_eq("fmt2_busy_wait", 32'(busy), 1);
    push(16'h0ABC);
    wait_pulses(base + 1, "fmt2_start");
    enable = 1'b0;
    wait_idle("fmt2_idle");
    e = '{56, 12, 22, 23, 24, 13, 132};
    check_frame("fmt2", base, e);

    // fmt7 all ones: full-length frame pads 30, short frame clamps to 12.
    b_hold = 1'b0;
    @(negedge clk_tx);
    push(16'hFFFF); push(16'h00FF);
    base = seen.size(); bbase = seen_b.size();
    run_one("fmt7", 3'd7, 1);
    e = '{56, 12, 27, 27, 27, 27, 27, 27, 22, 30};
    check_frame("fmt7", base, e);
    check_eq("fmt7_overrun_long", 32'(overrun), 0);
    check_eq("short_npulses", seen_b.size() - bbase, 10);
    check_eq("short_crc", 32'(seen_b[bbase + 8]), 22);
    check_eq("short_pause", 32'(seen_b[bbase + 9]), 12);
    check_eq("short_overrun", 32'(b_overrun), 1);

    // fmt3, enable dropped during DATA: frame still completes with pause.
    push(16'h0A5C);
    base = seen.size();
    run_one("drop", 3'd3, 3);
    e = '{56, 12, 17, 13, 15, 16, 22, 131};
    check_frame("drop", base, e);
    s0 = seen.size();
    repeat (20) @(negedge clk_tx);
    check_eq("drop_no_restart", seen.size() - s0, 0);
    check_eq("drop_busy", 32'(busy), 0);

    // Reset while the CRC pulse is outstanding.
    push(16'h0123);
    base = seen.size();
    frame_format = 3'd2; enable = 1'b1;
    wait_pulses(base + 6, "crc_reached");
    reset_tx = 1'b1; enable = 1'b0;
    @(posedge clk_tx);
    @(negedge clk_tx);
    check_eq("crcrst_pulse_start", 32'(pulse_start), 0);
    check_eq("crcrst_ticks", 32'(pulse_ticks), 0);
    check_eq("crcrst_busy", 32'(busy), 0);
    check_eq("crcrst_read_en", 32'(read_enable_fifo), 0);
    check_eq("crcrst_ack", 32'(serial_ack), 0);
    reset_tx = 1'b0;
    rd0 = n_rd; s0 = seen.size(); n = 0;
    push(16'h0456);
    frame_format = 3'd2; enable = 1'b1;
    while (n_rd == rd0 && seen.size() == s0 && n < 50) begin
      @(negedge clk_tx);
      n++;
    end
    check_eq("restart_pop_first", n_rd - rd0, 1);
    check_eq("restart_no_pulse_yet", seen.size() - s0, 0);
    wait_pulses(s0 + 1, "restart_start");
    enable = 1'b0;
    wait_idle("restart_idle");
    e = '{56, 12, 16, 17, 18, 23, 140};
    check_frame("restart", s0, e);

    // Short serial message over 16 frames: b2 set on frames 0 and 15.
    reset_tx = 1'b1;
    @(posedge clk_tx);
    @(negedge clk_tx);
    reset_tx = 1'b0;
    serial_valid = 1'b1; channel_format = 1'b0;
    serial_b2_in = 18'h08001; serial_b3_in = 18'h00000;
    for (int i = 0; i < 16; i++) push(16'h0000);
    base = seen.size(); rd0 = n_ack;
    frame_format = 3'd2; enable = 1'b1;
    wait_pulses(base + 15*7 + 1, "ser_last_frame");
    enable = 1'b0;
    wait_idle("ser_idle");
    check_eq("ser_npulses", seen.size() - base, 16*7);
    for (int f = 0; f < 16; f++)
      check_eq($sformatf("ser_status_f%0d", f), 32'(seen[base + f*7 + 1]),
               (f == 0 || f == 15) ? 16 : 12);
    check_eq("ser_ack_count", n_ack - rd0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
